demux16_router: RTL and testbench

//  1-to-2 demultiplexer for 16-bit words: the routing counterpart of the 2:1 mux16.

---
 rtl/demux16_router_pkg.sv | 10 +
 rtl/demux16_router_demux_slot.sv | 40 ++++
 rtl/demux16_router.sv | 68 ++++++
 tb/tb_demux16_router.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux16_router_pkg.sv
// Shared constants for the 1-to-2 word router: destination encodings and default sizes.
package demux16_router_pkg;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/demux16_router_demux_slot.sv
// One-entry output register slot with a delivered-word counter.
// A load takes priority over a drain, so a word can enter while the previous one leaves.
module demux_slot #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    logic drain;

    assign drain = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (drain) begin
                valid <= 1'b0;
            end
            // counter wraps silently
            if (drain) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/demux16_router.sv
// Steers one valid/ready word stream to one of two independently buffered sinks.
// Only the select decode and the in_ready mux live here; buffering is in demux_slot.
module demux16_router
    import demux16_router_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] out0_cnt,
    output logic [CNT_W-1:0] out1_cnt
);

    logic slot0_free;
    logic slot1_free;
    logic accept;
    logic load0;
    logic load1;

    // A slot can take a word if empty or if its current word leaves this cycle.
    assign slot0_free = !out0_valid || out0_ready;
    assign slot1_free = !out1_valid || out1_ready;

    assign in_ready = (in_sel == SEL_OUT1) ? slot1_free : slot0_free;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (in_sel == SEL_OUT0);
    assign load1    = accept && (in_sel == SEL_OUT1);

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .load_data (in_data),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .data      (out0_data),
        .cnt       (out0_cnt)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_data (in_data),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .data      (out1_data),
        .cnt       (out1_cnt)
    );

endmodule

// File: tb/tb_demux16_router.sv
// Directed bench for demux16_router with a per-output expected-word queue.
module tb_demux16_router;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [15:0] in_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] out1_data;
    logic [7:0]  out0_cnt;
    logic [7:0]  out1_cnt;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [7:0]  exp_cnt0;
    logic [7:0]  exp_cnt1;
    int          vectors;
    int          miscompares;

    demux16_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out0_cnt   (out0_cnt),
        .out1_cnt   (out1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_v0"}, {31'd0, out0_valid}, {31'd0, q0.size() != 0});
        check({tag, "_v1"}, {31'd0, out1_valid}, {31'd0, q1.size() != 0});
        if (q0.size() != 0) check({tag, "_d0"}, {16'd0, out0_data}, {16'd0, q0[0]});
        if (q1.size() != 0) check({tag, "_d1"}, {16'd0, out1_data}, {16'd0, q1[0]});
        check({tag, "_c0"}, {24'd0, out0_cnt}, {24'd0, exp_cnt0});
        check({tag, "_c1"}, {24'd0, out1_cnt}, {24'd0, exp_cnt1});
    endtask

    // Drive one cycle of stimulus, predict, clock, and compare after the edge.
    task automatic step(input string tag, input logic v, input logic sel, input logic [15:0] d,
                        input logic r0, input logic r1);
        logic        exp_rdy;
        logic [15:0] tmp;
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        exp_rdy = sel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
        check({tag, "_rdy"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        if (q0.size() != 0 && r0) begin
            tmp = q0.pop_front();
            exp_cnt0 = exp_cnt0 + 8'd1;
        end
        if (q1.size() != 0 && r1) begin
            tmp = q1.pop_front();
            exp_cnt1 = exp_cnt1 + 8'd1;
        end
        if (v && exp_rdy) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        exp_cnt0 = 8'd0;
        exp_cnt1 = 8'd0;
        check({tag, "_v0"}, {31'd0, out0_valid}, 32'd0);
        check({tag, "_v1"}, {31'd0, out1_valid}, 32'd0);
        check({tag, "_d0"}, {16'd0, out0_data}, 32'd0);
        check({tag, "_d1"}, {16'd0, out1_data}, 32'd0);
        check({tag, "_c0"}, {24'd0, out0_cnt}, 32'd0);
        check({tag, "_c1"}, {24'd0, out1_cnt}, 32'd0);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_sel = 1'b0;
        #1;
        check({tag, "_rdy_s0"}, {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1;
        check({tag, "_rdy_s1"}, {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt0    = 8'd0;
        exp_cnt1    = 8'd0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sel      = 1'b0;
        in_data     = 16'h0000;
        out0_ready  = 1'b0;
        out1_ready  = 1'b0;
        #2;
        do_reset("por");

        // route a single word to out0
        step("route", 1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b0);
        check("route_d0", {16'd0, out0_data}, 32'h0000A5A5);
        step("route_drain", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("route_cnt0", {24'd0, out0_cnt}, 32'd1);

        // out1 stalls; out0 must still accept
        step("bp_a", 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
        step("bp_b", 1'b1, 1'b1, 16'h5678, 1'b1, 1'b0);
        check("bp_hold1", {16'd0, out1_data}, 32'h00001234);
        step("bp_c", 1'b1, 1'b1, 16'h5678, 1'b1, 1'b0);
        step("bp_hol", 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
        check("bp_d0", {16'd0, out0_data}, 32'h0000BEEF);
        check("bp_hold1b", {16'd0, out1_data}, 32'h00001234);
        step("bp_drain", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // mid-simulation reset
        do_reset("rst_mid");

        // back-to-back streaming, including load-and-drain in the same cycle
        for (int i = 1; i <= 4; i++) begin
            step("stream", 1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
        end
        step("stream_end", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("stream_cnt0", {24'd0, out0_cnt}, 32'd4);

        // 256 deliveries on out1 wrap its counter back to zero
        for (int i = 0; i < 256; i++) begin
            step("wrap", 1'b1, 1'b1, 16'(16'h8000 + i), 1'b0, 1'b1);
        end
        step("wrap_end", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        check("wrap_cnt1", {24'd0, out1_cnt}, 32'd0);
        check("wrap_cnt0", {24'd0, out0_cnt}, 32'd4);

        // random traffic with random sink stalls
        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        step("rand_end", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // reset while out0 is stalled on a word
        step("stall", 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
        check("stall_d0", {16'd0, out0_data}, 32'h0000CAFE);
        do_reset("rst_stall");
        for (int i = 0; i < 3; i++) begin
            step("post_rst", 1'b0, 1'b0, 16'hCAFE, 1'b1, 1'b1);
        end
        check("post_rst_c0", {24'd0, out0_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
